// File: rtl/filter_pkg.sv
// Shared types, kernel coefficient tables and saturation helper for the filter sequencer.
package filter_pkg;

   typedef enum logic [1:0] {
      BLUR    = 2'd0,
      SHARPEN = 2'd1,
      EDGE    = 2'd2,
      IDENT   = 2'd3
   } kernel_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_LAST,
      S_WRITE,
      S_DONE
   } seq_state_e;

   // Coefficient for tap 0..8 (row-major). The edge kernel centre of 8 needs a fifth bit.
   function automatic logic signed [4:0] coef(input kernel_e k, input logic [3:0] tap);
      logic signed [4:0] c;
      c = 5'sd0;
      case (k)
         BLUR: begin
            case (tap)
               4'd0, 4'd2, 4'd6, 4'd8: c = 5'sd1;
               4'd1, 4'd3, 4'd5, 4'd7: c = 5'sd2;
               4'd4:                   c = 5'sd4;
               default:                c = 5'sd0;
            endcase
         end
         SHARPEN: begin
            case (tap)
               4'd1, 4'd3, 4'd5, 4'd7: c = -5'sd1;
               4'd4:                   c = 5'sd5;
               default:                c = 5'sd0;
            endcase
         end
         EDGE: begin
            case (tap)
               4'd4:    c = 5'sd8;
               default: c = (tap < 4'd9) ? -5'sd1 : 5'sd0;
            endcase
         end
         default: c = (tap == 4'd4) ? 5'sd1 : 5'sd0;
      endcase
      return c;
   endfunction

   function automatic logic [2:0] shift_of(input kernel_e k);
      return (k == BLUR) ? 3'd4 : 3'd0;
   endfunction

   function automatic logic [7:0] sat8(input logic signed [15:0] v);
      if (v < 16'sd0)        return 8'd0;
      else if (v > 16'sd255) return 8'hFF;
      else                   return v[7:0];
   endfunction

endpackage

// File: rtl/filter_btn_edge.sv
// Two-flop synchroniser for an active-low button followed by a falling-edge pulse.
module filter_btn_edge (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic fall
);

   logic s1, s2, s3;

   // Synchronise and keep the previous synchronised level; idle level is high.
   always_ff @(posedge clk) begin
      if (!reset) begin
         s1 <= 1'b1;
         s2 <= 1'b1;
         s3 <= 1'b1;
      end else begin
         s1 <= btn;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign fall = s3 & ~s2;

endmodule

// File: rtl/filter_sequencer.sv
// Frame convolution sequencer: walks the frame, reads 3x3 neighbourhoods, MACs and writes.
module filter_sequencer
   import filter_pkg::*;
#(
   parameter int          IMG_W    = 64,
   parameter int          IMG_H    = 64,
   parameter int unsigned SRC_BASE = 0,
   parameter int unsigned DST_BASE = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        kernel1,
   input  logic        kernel2,
   input  logic        kernel3,
   input  logic [31:0] ReadData,
   output logic        MemWrite,
   output logic [31:0] DataAdr,
   output logic [31:0] WriteData,
   output logic [1:0]  kernel,
   output logic        busy,
   output logic        done
);

   localparam int XW = $clog2(IMG_W);
   localparam int YW = $clog2(IMG_H);

   seq_state_e        state, state_nxt;
   kernel_e           kern, start_id;
   logic [XW-1:0]     x, tx;
   logic [YW-1:0]     y, ty;
   logic [3:0]        tap, mac_tap, row, col;
   logic signed [15:0] acc, prod, c16, pix16;
   logic [7:0]        pix, result, wd_q;
   logic              f1, f2, f3, start, border, last_px, unused_bits;

   filter_btn_edge u_btn1 (.clk(clk), .reset(reset), .btn(kernel1), .fall(f1));
   filter_btn_edge u_btn2 (.clk(clk), .reset(reset), .btn(kernel2), .fall(f2));
   filter_btn_edge u_btn3 (.clk(clk), .reset(reset), .btn(kernel3), .fall(f3));

   assign start       = f1 | f2 | f3;
   assign pix         = ReadData[7:0];
   assign unused_bits = ^ReadData[31:8];
   assign border      = (x == '0) || (x == XW'(IMG_W - 1)) || (y == '0) || (y == YW'(IMG_H - 1));
   assign last_px     = (x == XW'(IMG_W - 1)) && (y == YW'(IMG_H - 1));
   assign row         = tap / 4'd3;
   assign col         = tap % 4'd3;
   // ReadData lags DataAdr by one cycle, so READ consumes the previous tap and LAST takes tap 8.
   assign mac_tap     = (state == S_LAST) ? 4'd8 : tap - 4'd1;
   assign c16         = 16'(coef(kern, mac_tap));
   assign pix16       = $signed({8'd0, pix});
   assign prod        = c16 * pix16;
   assign result      = border ? acc[7:0] : sat8(acc >>> shift_of(kern));
   assign kernel      = kern;
   assign WriteData   = {24'd0, (state == S_WRITE) ? result : wd_q};

   // Button priority: kernel1 over kernel2 over kernel3.
   always_comb begin
      start_id = EDGE;
      if (f1)      start_id = BLUR;
      else if (f2) start_id = SHARPEN;
   end

   // Neighbour coordinates for the current tap; borders read only their own pixel.
   always_comb begin
      tx = x;
      ty = y;
      if (!border) begin
         tx = x + XW'(col) - XW'(1);
         ty = y + YW'(row) - YW'(1);
      end
   end

   // State register plus scan position, accumulator and write-data hold.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= S_IDLE;
         kern  <= BLUR;
         x     <= '0;
         y     <= '0;
         tap   <= '0;
         acc   <= '0;
         wd_q  <= '0;
      end else begin
         state <= state_nxt;
         if (start) begin
            kern <= start_id;
            x    <= '0;
            y    <= '0;
            tap  <= '0;
            acc  <= '0;
         end else begin
            case (state)
               S_READ: begin
                  if (tap != 4'd0) acc <= acc + prod;
                  tap <= tap + 4'd1;
               end
               S_LAST: acc <= border ? pix16 : acc + prod;
               S_WRITE: begin
                  wd_q <= result;
                  tap  <= '0;
                  acc  <= '0;
                  if (x == XW'(IMG_W - 1)) begin
                     x <= '0;
                     y <= y + YW'(1);
                  end else begin
                     x <= x + XW'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Next-state and dmem port drive; a button edge overrides everything, suppressing any write.
   always_comb begin
      state_nxt = state;
      MemWrite  = 1'b0;
      DataAdr   = '0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         S_READ: begin
            busy    = 1'b1;
            DataAdr = SRC_BASE + 32'({ty, tx});
            if (border || tap == 4'd8) state_nxt = S_LAST;
         end
         S_LAST: begin
            busy      = 1'b1;
            state_nxt = S_WRITE;
         end
         S_WRITE: begin
            busy      = 1'b1;
            MemWrite  = ~start;
            DataAdr   = DST_BASE + 32'({y, x});
            state_nxt = last_px ? S_DONE : S_READ;
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: ;
      endcase
      if (start) state_nxt = S_READ;
   end

endmodule

// File: tb/tb_filter_sequencer.sv
// Self-checking bench for filter_sequencer on a 4x4 frame with a 1-cycle-latency dmem model.
module tb_filter_sequencer;

   localparam int W   = 4;
   localparam int H   = 4;
   localparam int DST = 4096;

   logic        clk = 1'b0;
   logic        reset, kernel1, kernel2, kernel3;
   logic [31:0] ReadData = '0;
   logic        MemWrite, busy, done;
   logic [31:0] DataAdr, WriteData;
   logic [1:0]  kernel;

   filter_sequencer #(
      .IMG_W(W), .IMG_H(H), .SRC_BASE(0), .DST_BASE(DST)
   ) dut (
      .clk(clk), .reset(reset), .kernel1(kernel1), .kernel2(kernel2), .kernel3(kernel3),
      .ReadData(ReadData), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
      .kernel(kernel), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int src[16];
   int cyc = 0;
   int wr_adr[$], wr_dat[$], wr_cyc[$], done_cyc[$], done_busy[$];
   int total = 0, bad = 0;

   int kc[3][9] = '{'{1, 2, 1, 2, 4, 2, 1, 2, 1},
                    '{0, -1, 0, -1, 5, -1, 0, -1, 0},
                    '{-1, -1, -1, -1, 8, -1, -1, -1, -1}};
   int ksh[3] = '{4, 0, 0};

   always @(posedge clk) cyc <= cyc + 1;

   // dmem: source frame readable, data valid one cycle after the address.
   always @(posedge clk)
      ReadData <= (DataAdr < 32'd16) ? 32'(src[DataAdr[3:0]] & 255) : 32'd0;

   always @(negedge clk) begin
      if (MemWrite) begin
         wr_adr.push_back(DataAdr);
         wr_dat.push_back(WriteData);
         wr_cyc.push_back(cyc);
      end
      if (done) begin
         done_cyc.push_back(cyc);
         done_busy.push_back(busy);
      end
   end

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   function automatic bit interior(int px, int py);
      return px > 0 && px < W - 1 && py > 0 && py < H - 1;
   endfunction

   function automatic int model_px(int k, int px, int py);
      int s = 0;
      if (!interior(px, py)) return src[py * W + px];
      for (int dy = -1; dy <= 1; dy++)
         for (int dx = -1; dx <= 1; dx++)
            s += kc[k][(dy + 1) * 3 + dx + 1] * src[(py + dy) * W + px + dx];
      s = s >>> ksh[k];
      if (s < 0) s = 0;
      if (s > 255) s = 255;
      return s;
   endfunction

   task automatic press(input bit b1, input bit b2, input bit b3);
      @(negedge clk);
      kernel1 = !b1; kernel2 = !b2; kernel3 = !b3;
      repeat (3) @(negedge clk);
      kernel1 = 1'b1; kernel2 = 1'b1; kernel3 = 1'b1;
   endtask

   task automatic check_pass(input int from, input int k, input string tag);
      chk($sformatf("%s writes", tag), wr_adr.size() - from, 16);
      if (wr_adr.size() < from + 16) return;
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("%s adr[%0d]", tag, i), wr_adr[from + i], DST + i);
         chk($sformatf("%s px[%0d]", tag, i), wr_dat[from + i], model_px(k, i % W, i / W));
         if (i > 0)
            chk($sformatf("%s gap[%0d]", tag, i), wr_cyc[from + i] - wr_cyc[from + i - 1],
                interior(i % W, i / W) ? 11 : 3);
      end
   endtask

   task automatic wait_done(input int nd, input string tag);
      int n = 0;
      while (done_cyc.size() < nd && n < 600) begin
         @(negedge clk);
         n++;
      end
      repeat (6) @(negedge clk);
      chk($sformatf("%s done count", tag), done_cyc.size(), nd);
      if (done_cyc.size() >= nd && wr_cyc.size() > 0) begin
         chk($sformatf("%s done timing", tag), done_cyc[nd - 1], wr_cyc[wr_cyc.size() - 1] + 1);
         chk($sformatf("%s busy at done", tag), done_busy[nd - 1], 0);
      end
      chk($sformatf("%s busy after", tag), busy, 0);
   endtask

   task automatic run_pass(input bit b1, input bit b2, input bit b3, input int k, input string tag);
      int ws = wr_adr.size();
      int nd = done_cyc.size() + 1;
      press(b1, b2, b3);
      wait_done(nd, tag);
      check_pass(ws, k, tag);
      chk($sformatf("%s kernel", tag), kernel, k);
   endtask

   typedef struct {
      bit b1, b2, b3;
      int kid;
      int pat;    // 0: uniform a; 1: pixel (1,1)=a, rest b
      int a, b;
      int exp11;  // expected output at pixel (1,1)
   } vec_t;

   initial begin
      vec_t tbl[5];
      int ws, nd, p, j, n, sel;

      tbl[0] = '{1, 0, 0, 0, 0, 100, 0, 100};
      tbl[1] = '{0, 0, 1, 2, 1, 255, 0, 255};
      tbl[2] = '{0, 0, 1, 2, 0, 50, 0, 0};
      tbl[3] = '{0, 1, 0, 1, 1, 0, 255, 0};
      tbl[4] = '{0, 1, 0, 1, 0, 80, 0, 80};

      reset = 1'b0; kernel1 = 1'b1; kernel2 = 1'b1; kernel3 = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst MemWrite", MemWrite, 0);
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst kernel", kernel, 0);
      chk("rst DataAdr", DataAdr, 0);
      reset = 1'b1;

      foreach (tbl[t]) begin
         for (int i = 0; i < 16; i++) src[i] = (tbl[t].pat == 0 || i == 5) ? tbl[t].a : tbl[t].b;
         ws = wr_adr.size();
         run_pass(tbl[t].b1, tbl[t].b2, tbl[t].b3, tbl[t].kid, $sformatf("tbl%0d", t));
         if (wr_dat.size() >= ws + 6) chk($sformatf("tbl%0d centre", t), wr_dat[ws + 5], tbl[t].exp11);
      end

      // Abort a blur pass with sharpen partway through.
      for (int i = 0; i < 16; i++) src[i] = $urandom_range(0, 255);
      ws = wr_adr.size();
      nd = done_cyc.size() + 1;
      press(1, 0, 0);
      n = 0;
      while (wr_adr.size() < ws + 5 && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("abort pre writes", wr_adr.size() >= ws + 5, 1);
      kernel2 = 1'b0;
      p = cyc;
      repeat (3) @(negedge clk);
      chk("abort MemWrite n3", MemWrite, 0);
      @(negedge clk);
      chk("abort MemWrite n4", MemWrite, 0);
      kernel2 = 1'b1;
      wait_done(nd, "abort");
      j = ws;
      while (j < wr_cyc.size() && wr_cyc[j] < p + 3) j++;
      check_pass(j, 1, "abort");
      chk("abort kernel", kernel, 1);

      // Simultaneous kernel1 and kernel3: kernel1 wins.
      for (int i = 0; i < 16; i++) src[i] = $urandom_range(0, 255);
      run_pass(1, 0, 1, 0, "dual");

      // Reset in the middle of an edge pass.
      ws = wr_adr.size();
      press(0, 0, 1);
      n = 0;
      while (wr_adr.size() < ws + 3 && n < 400) begin
         @(negedge clk);
         n++;
      end
      reset = 1'b0;
      @(negedge clk);
      chk("midrst busy", busy, 0);
      chk("midrst MemWrite", MemWrite, 0);
      chk("midrst DataAdr", DataAdr, 0);
      chk("midrst kernel", kernel, 0);
      reset = 1'b1;
      ws = wr_adr.size();
      nd = done_cyc.size();
      repeat (80) @(negedge clk);
      chk("midrst no writes", wr_adr.size(), ws);
      chk("midrst no done", done_cyc.size(), nd);

      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 16; i++) src[i] = $urandom_range(0, 255);
         sel = $urandom_range(0, 2);
         run_pass(sel == 0, sel == 1, sel == 2, sel, $sformatf("rand%0d", r));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
